// File: rtl/bn_param_loader_if.sv
// Byte-stream handshake into the batch-norm parameter loader.
// A byte transfers on a rising edge where in_valid and in_ready are both high.
interface bn_param_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bn_param_loader.sv
// Packet-based writer of per-neuron batch-norm factor/addend pairs with a combinational read port.
// Optional build macro BN_SHADOW_EN: stage writes in a shadow bank, copied to the active bank on commit.
module bn_param_loader #(
    parameter int NEURONS      = 8,
    parameter int WIDTH        = 6,
    parameter int ADDEND_WIDTH = WIDTH - 2,
    localparam int IW          = $clog2(NEURONS)
) (
    input  logic                           clk,
    input  logic                           reset,
    bn_param_loader_if.slave               stream,
    input  logic [IW-1:0]                  rd_index,
    output logic [3:0]                     BN_factor,
    output logic signed [ADDEND_WIDTH-1:0] BN_addend,
    output logic                           load_done,
    output logic                           err
);

    typedef enum logic [1:0] {IDLE, COUNT, DATA, COMMIT} state_t;

    state_t      state;
    logic [IW-1:0] idx;
    logic [7:0]  remaining;
    logic        accept;
    logic [7:0]  d;

    logic [3:0]                     act_factor [NEURONS];
    logic signed [ADDEND_WIDTH-1:0] act_addend [NEURONS];
`ifdef BN_SHADOW_EN
    logic [3:0]                     sh_factor  [NEURONS];
    logic signed [ADDEND_WIDTH-1:0] sh_addend  [NEURONS];
`endif

    assign accept = stream.in_valid & stream.in_ready;
    assign d      = stream.in_data;

    assign BN_factor = act_factor[rd_index];
    assign BN_addend = act_addend[rd_index];

    function automatic logic header_ok(logic [7:0] b);
        return b[7] && ({1'b0, b[6:0]} < 8'(NEURONS));
    endfunction

    function automatic logic count_ok(logic [7:0] b);
        return (b != 8'd0) && (b <= 8'(NEURONS));
    endfunction

    // Reserved factor codes, a zero-only bypass code, and addends that do not fit ADDEND_WIDTH are rejected.
    function automatic logic data_ok(logic [7:0] b);
        logic signed [ADDEND_WIDTH-1:0] a;
        logic [3:0]                     ext;
        logic                           ok;
        a   = b[ADDEND_WIDTH-1:0];
        ext = 4'(a);
        ok  = (ext == b[3:0]);
        case (b[7:4])
            4'b0000, 4'b0111, 4'b1011, 4'b1111: ok = 1'b0;
            4'b0011: if (b[3:0] != 4'd0) ok = 1'b0;
            default: ;
        endcase
        return ok;
    endfunction

    function automatic logic [IW-1:0] next_index(logic [IW-1:0] i);
        return (i == IW'(NEURONS - 1)) ? '0 : i + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            remaining       <= '0;
            stream.in_ready <= 1'b0;
            load_done       <= 1'b0;
            err             <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                act_factor[i] <= 4'b0100;
                act_addend[i] <= '0;
`ifdef BN_SHADOW_EN
                sh_factor[i]  <= 4'b0100;
                sh_addend[i]  <= '0;
`endif
            end
        end else begin
            load_done       <= 1'b0;
            stream.in_ready <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    if (header_ok(d)) begin
                        err   <= 1'b0;
                        idx   <= d[IW-1:0];
                        state <= COUNT;
                    end else begin
                        err   <= 1'b1;
                    end
                end
                COUNT: if (accept) begin
                    if (count_ok(d)) begin
                        remaining <= d;
                        state     <= DATA;
                    end else begin
                        err       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DATA: if (accept) begin
                    if (data_ok(d)) begin
`ifdef BN_SHADOW_EN
                        sh_factor[idx]  <= d[7:4];
                        sh_addend[idx]  <= d[ADDEND_WIDTH-1:0];
`else
                        act_factor[idx] <= d[7:4];
                        act_addend[idx] <= d[ADDEND_WIDTH-1:0];
`endif
                    end else begin
                        err <= 1'b1;
                    end
                    idx       <= next_index(idx);
                    remaining <= remaining - 8'd1;
                    // Last byte: drop ready now so the commit cycle is a registered bubble.
                    if (remaining == 8'd1) begin
                        state           <= COMMIT;
                        load_done       <= 1'b1;
                        stream.in_ready <= 1'b0;
                    end
                end
                COMMIT: begin
`ifdef BN_SHADOW_EN
                    act_factor <= sh_factor;
                    act_addend <= sh_addend;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bn_param_loader.sv
// Self-checking bench for bn_param_loader: packet vector table, commit scoreboard, stall and reset sequences.
// Build with or without BN_SHADOW_EN to match the RTL configuration.
module tb_bn_param_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rd_index;
    logic [3:0] BN_factor;
    logic signed [3:0] BN_addend;
    logic       load_done;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic sb_q[$];
    logic ld_prev = 1'b0;

    bn_param_loader_if bus ();

    bn_param_loader #(.NEURONS(8), .WIDTH(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .stream    (bus),
        .rd_index  (rd_index),
        .BN_factor (BN_factor),
        .BN_addend (BN_addend),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       n;
        logic [4:0][7:0]  b;
        logic             e_err;
        logic             e_done;
        logic [1:0]       nck;
        logic [2:0][2:0]  ci;
        logic [2:0][3:0]  cf;
        logic [2:0][3:0]  ca;
    } vec_t;

    vec_t tbl [9];

    // Bytes and checks listed first-to-last, most significant field first.
    function automatic vec_t mk(int n, logic [39:0] bytes, logic e, logic dn, int nck,
                                logic [8:0] ci, logic [11:0] cf, logic [11:0] ca);
        vec_t v;
        v = '0;
        v.n = 3'(n);
        for (int k = 0; k < 5; k++) v.b[k] = bytes[39-8*k -: 8];
        v.e_err = e;
        v.e_done = dn;
        v.nck = 2'(nck);
        for (int k = 0; k < 3; k++) begin
            v.ci[k] = ci[8-3*k -: 3];
            v.cf[k] = cf[11-4*k -: 4];
            v.ca[k] = ca[11-4*k -: 4];
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input int i, input logic [3:0] f, input logic [3:0] a, input string tag);
        logic [3:0] a_u;
        rd_index = 3'(i);
        #1;
        a_u = BN_addend;
        chk($sformatf("%s_f%0d", tag, i), {4'h0, BN_factor}, {4'h0, f});
        chk($sformatf("%s_a%0d", tag, i), {4'h0, a_u}, {4'h0, a});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout byte=%0h actual=0 required=1", b);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: every commit pulse must have been announced, last one cycle, and hold ready low.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_done) begin
                chk("done_ready", {7'd0, bus.in_ready}, 8'd0);
                chk("done_width", {7'd0, ld_prev}, 8'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    chk("done_err", {7'd0, err}, {7'd0, sb_q.pop_front()});
                end
            end
            ld_prev = load_done;
        end else begin
            ld_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rd_index     = 3'd0;

        tbl[0] = mk(5, 40'h82_03_5F_1A_30, 1'b0, 1'b1, 3, {3'd2, 3'd3, 3'd4}, 12'h513, 12'hFA0);
        tbl[1] = mk(4, 40'h80_02_71_31_00, 1'b1, 1'b1, 3, {3'd0, 3'd1, 3'd2}, 12'h445, 12'h00F);
        tbl[2] = mk(3, 40'h80_01_40_00_00, 1'b0, 1'b1, 1, {3'd0, 3'd0, 3'd0}, 12'h400, 12'h000);
        tbl[3] = mk(4, 40'h87_02_20_C0_00, 1'b0, 1'b1, 3, {3'd7, 3'd0, 3'd3}, 12'h2C1, 12'h00A);
        tbl[4] = mk(1, 40'h05_00_00_00_00, 1'b1, 1'b0, 1, {3'd3, 3'd0, 3'd0}, 12'h100, 12'hA00);
        tbl[5] = mk(3, 40'h81_01_2F_00_00, 1'b0, 1'b1, 2, {3'd1, 3'd7, 3'd0}, 12'h220, 12'hF00);
        tbl[6] = mk(1, 40'h89_00_00_00_00, 1'b1, 1'b0, 1, {3'd1, 3'd0, 3'd0}, 12'h200, 12'hF00);
        tbl[7] = mk(2, 40'h80_00_00_00_00, 1'b1, 1'b0, 1, {3'd0, 3'd0, 3'd0}, 12'hC00, 12'h000);
        tbl[8] = mk(3, 40'h81_01_9E_00_00, 1'b0, 1'b1, 2, {3'd1, 3'd0, 3'd0}, 12'h9C0, 12'hE00);

        // Power-on reset and defaults
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {7'd0, bus.in_ready}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_done", {7'd0, load_done}, 8'd0);
        for (int i = 0; i < 8; i++) check_entry(i, 4'b0100, 4'h0, "rst");
        @(posedge clk);
        #1;
        chk("rst_ready_after", {7'd0, bus.in_ready}, 8'd1);

        // Packet table
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < int'(tbl[r].n); k++) begin
                if (k == int'(tbl[r].n) - 1 && tbl[r].e_done) sb_q.push_back(tbl[r].e_err);
                send_byte(tbl[r].b[k]);
            end
            idle(2);
            chk($sformatf("row%0d_err", r), {7'd0, err}, {7'd0, tbl[r].e_err});
            for (int c = 0; c < int'(tbl[r].nck); c++)
                check_entry(int'(tbl[r].ci[c]), tbl[r].cf[c], tbl[r].ca[c], $sformatf("row%0d", r));
        end

        // Stalled packet: entry 0 = C/0 and entry 1 = 9/-2 beforehand
        send_byte(8'h80);
        idle(3);
        send_byte(8'h02);
        idle(2);
        chk("stall_ready", {7'd0, bus.in_ready}, 8'd1);
        send_byte(8'h40);
        idle(4);
        chk("stall_done", {7'd0, load_done}, 8'd0);
`ifdef BN_SHADOW_EN
        check_entry(0, 4'hC, 4'h0, "stall_mid");
`else
        check_entry(0, 4'h4, 4'h0, "stall_mid");
`endif
        check_entry(1, 4'h9, 4'hE, "stall_mid");
        sb_q.push_back(1'b0);
        send_byte(8'h80);
`ifdef BN_SHADOW_EN
        check_entry(1, 4'h9, 4'hE, "stall_commit");
        check_entry(0, 4'hC, 4'h0, "stall_commit");
        @(posedge clk);
        #1;
`endif
        check_entry(1, 4'h8, 4'h0, "stall_after");
        check_entry(0, 4'h4, 4'h0, "stall_after");

        // Reset in the middle of a packet
        idle(2);
        send_byte(8'h83);
        send_byte(8'h03);
        send_byte(8'h5F);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {7'd0, bus.in_ready}, 8'd0);
        chk("mid_rst_err", {7'd0, err}, 8'd0);
        chk("mid_rst_done", {7'd0, load_done}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) check_entry(i, 4'b0100, 4'h0, "mid_rst");
        @(posedge clk);
        #1;
        chk("mid_rst_ready_after", {7'd0, bus.in_ready}, 8'd1);
        sb_q.push_back(1'b0);
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h5F);
        idle(2);
        check_entry(0, 4'h5, 4'hF, "post_rst");
        check_entry(3, 4'h4, 4'h0, "post_rst");

        idle(2);
        chk("sb_pending", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
